// File: rtl/log_dump.sv
// Streams a header plus the contents of a log RAM to a byte-wide UART interface.
// Sequence: 0xA5, len[15:8], len[7:0], then three bytes per log word, MSB first.
module log_dump #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] dump_len,
  output logic                  u_rd,
  output logic [ADDR_WIDTH-1:0] u_addr,
  input  logic [23:0]           u_data_out,
  input  logic                  u_data_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    RD_REQ,
    RD_WAIT,
    SEND,
    FIN
  } state_e;

  state_e                state_q,    state_d;
  logic [ADDR_WIDTH-1:0] len_q,      len_d;
  logic [ADDR_WIDTH:0]   entry_q,    entry_d;
  logic [1:0]            byte_q,     byte_d;
  logic [23:0]           hold_q,     hold_d;
  logic                  u_rd_q,     u_rd_d;
  logic [ADDR_WIDTH-1:0] u_addr_q,   u_addr_d;
  logic [7:0]            tx_data_q,  tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  busy_q,     busy_d;
  logic                  done_q,     done_d;

  logic [15:0]           len16;
  logic [ADDR_WIDTH:0]   entry_nxt;
  logic                  xfer;

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    entry_d    = entry_q;
    byte_d     = byte_q;
    hold_d     = hold_q;
    u_addr_d   = u_addr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    u_rd_d     = 1'b0;
    done_d     = 1'b0;

    len16                   = '0;
    len16[ADDR_WIDTH-1:0]   = len_q;
    entry_nxt               = entry_q + 1'b1;
    xfer                    = tx_valid_q && tx_ready;

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d      = dump_len;
          entry_d    = '0;
          byte_d     = '0;
          busy_d     = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = 8'hA5;
          state_d    = HDR;
        end
      end

      HDR: begin
        if (xfer) begin
          byte_d = byte_q + 2'd1;
          case (byte_q)
            2'd0:    tx_data_d = len16[15:8];
            2'd1:    tx_data_d = len16[7:0];
            default: begin
              byte_d     = '0;
              tx_valid_d = 1'b0;
              if (len_q != '0) begin
                u_rd_d   = 1'b1;
                u_addr_d = entry_q[ADDR_WIDTH-1:0];
                state_d  = RD_REQ;
              end else begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = FIN;
              end
            end
          endcase
        end
      end

      RD_REQ: state_d = RD_WAIT;

      // Returns arriving in any other state are stale and dropped.
      RD_WAIT: begin
        if (u_data_valid) begin
          hold_d     = u_data_out;
          byte_d     = '0;
          tx_valid_d = 1'b1;
          tx_data_d  = u_data_out[23:16];
          state_d    = SEND;
        end
      end

      SEND: begin
        if (xfer) begin
          byte_d = byte_q + 2'd1;
          case (byte_q)
            2'd0:    tx_data_d = hold_q[15:8];
            2'd1:    tx_data_d = hold_q[7:0];
            default: begin
              byte_d     = '0;
              tx_valid_d = 1'b0;
              entry_d    = entry_nxt;
              // Index is one bit wider than the address so len = DEPTH-1 cannot wrap.
              if (entry_nxt < {1'b0, len_q}) begin
                u_rd_d   = 1'b1;
                u_addr_d = entry_nxt[ADDR_WIDTH-1:0];
                state_d  = RD_REQ;
              end else begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = FIN;
              end
            end
          endcase
        end
      end

      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      entry_q    <= '0;
      byte_q     <= '0;
      hold_q     <= '0;
      u_rd_q     <= 1'b0;
      u_addr_q   <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      entry_q    <= entry_d;
      byte_q     <= byte_d;
      hold_q     <= hold_d;
      u_rd_q     <= u_rd_d;
      u_addr_q   <= u_addr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign u_rd     = u_rd_q;
  assign u_addr   = u_addr_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
